// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser, consecutive-sample debounce FSM, registered level and edge pulses.
// Define BUTTON_DEBOUNCE_LONGPRESS_EN to build the long-press pulse; otherwise btn_long is tied to 0.
//
// state     | meaning
// LOW       | accepted level 0, synchronised input agrees
// RISE_WAIT | accepted level 0, counting consecutive 1 samples
// HIGH      | accepted level 1, synchronised input agrees
// FALL_WAIT | accepted level 1, counting consecutive 0 samples
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_long
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam bit            SINGLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sync1;
    logic          r_s;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
        end else begin
            r_sync1 <= button;
            r_s     <= r_sync1;
        end
    end

    // Pulses default low every cycle, so each acceptance yields exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                LOW: begin
                    if (r_s) begin
                        if (SINGLE) begin
                            r_state <= HIGH;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_state <= RISE_WAIT;
                            r_cnt   <= C_ONE;
                        end
                    end
                end
                RISE_WAIT: begin
                    if (!r_s) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                HIGH: begin
                    if (!r_s) begin
                        if (SINGLE) begin
                            r_state <= LOW;
                            r_cnt   <= '0;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_state <= FALL_WAIT;
                            r_cnt   <= C_ONE;
                        end
                    end
                end
                FALL_WAIT: begin
                    if (r_s) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= LOW;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;
    assign btn_fall  = r_fall;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam int            LW    = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] L_MAX = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] L_PEN = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] L_ONE = LW'(1);

    logic [LW-1:0] r_lcnt;
    logic          r_long;

    // Saturation at L_MAX is what limits the pulse to one per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcnt <= '0;
            r_long <= 1'b0;
        end else if (!r_level) begin
            r_lcnt <= '0;
            r_long <= 1'b0;
        end else if (r_lcnt != L_MAX) begin
            r_lcnt <= r_lcnt + L_ONE;
            r_long <= (r_lcnt == L_PEN);
        end else begin
            r_long <= 1'b0;
        end
    end

    assign btn_long = r_long;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: expected pulses (kind, edge) are queued at stimulus time and matched against observed pulses.
module tb_button_debounce;

    localparam int DB = 4;
    localparam int LG = 10;
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    // kind: 0 = rise, 1 = fall, 2 = long
    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic button = 1'b0;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic btn_long;

    int  total      = 0;
    int  bad        = 0;
    int  edge_n     = 0;
    bit  watch_long = 1'b0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    button_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .button   (button),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_long (btn_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic ev_t mk(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        return e;
    endfunction

    // Edge at which a level first sampled on the next edge is accepted.
    function automatic int accept_edge();
        return edge_n + 1 + DB + 1;
    endfunction

    task automatic tick(input logic b);
        @(negedge clk);
        button = b;
        @(posedge clk);
        #1;
        if (btn_rise) obs_q.push_back(mk(0, edge_n));
        if (btn_fall) obs_q.push_back(mk(1, edge_n));
        if (btn_long && (watch_long || !LONG_EN)) obs_q.push_back(mk(2, edge_n));
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        button = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({btn_level, btn_rise, btn_fall, btn_long} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000", {btn_level, btn_rise, btn_fall, btn_long});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(0, accept_edge()));
        hold(1'b1, 12);
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_level: got %b want 1", btn_level);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            ev_t e;
            ev_t o;
            e = mk(-1, -1);
            o = mk(-1, -1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            total++;
            if (o.kind !== e.kind || o.at !== e.at) begin
                bad++;
                $display("FAIL reset_release: got kind=%0d edge=%0d want kind=%0d edge=%0d", o.kind, o.at, e.kind, e.at);
            end
        end
    endtask

    task automatic test_clean_press_release();
        exp_q.push_back(mk(1, accept_edge()));
        hold(1'b0, 12);
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL clean_release_level: got %b want 0", btn_level);
        end
        exp_q.push_back(mk(0, accept_edge()));
        hold(1'b1, 12);
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL clean_press_level: got %b want 1", btn_level);
        end
        exp_q.push_back(mk(1, accept_edge()));
        hold(1'b0, 12);
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL clean_release2_level: got %b want 0", btn_level);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            ev_t e;
            ev_t o;
            e = mk(-1, -1);
            o = mk(-1, -1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            total++;
            if (o.kind !== e.kind || o.at !== e.at) begin
                bad++;
                $display("FAIL clean: got kind=%0d edge=%0d want kind=%0d edge=%0d", o.kind, o.at, e.kind, e.at);
            end
        end
    endtask

    task automatic test_bounce();
        bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int base;
        base = edge_n;
        // Final 0->1 sample lands on edge base+6.
        exp_q.push_back(mk(0, base + 6 + DB + 1));
        for (int i = 0; i < 6; i++) tick(pat[i]);
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL bounce_level_during: got %b want 0", btn_level);
        end
        hold(1'b1, 12);
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL bounce_level_after: got %b want 1", btn_level);
        end
        exp_q.push_back(mk(1, accept_edge()));
        hold(1'b0, 12);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            ev_t e;
            ev_t o;
            e = mk(-1, -1);
            o = mk(-1, -1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            total++;
            if (o.kind !== e.kind || o.at !== e.at) begin
                bad++;
                $display("FAIL bounce: got kind=%0d edge=%0d want kind=%0d edge=%0d", o.kind, o.at, e.kind, e.at);
            end
        end
    endtask

    task automatic test_glitch_high();
        exp_q.push_back(mk(0, accept_edge()));
        hold(1'b1, 12);
        hold(1'b0, DB - 1);
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL glitch_level_mid: got %b want 1", btn_level);
        end
        hold(1'b1, 10);
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL glitch_level_after: got %b want 1", btn_level);
        end
        exp_q.push_back(mk(1, accept_edge()));
        hold(1'b0, 12);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            ev_t e;
            ev_t o;
            e = mk(-1, -1);
            o = mk(-1, -1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            total++;
            if (o.kind !== e.kind || o.at !== e.at) begin
                bad++;
                $display("FAIL glitch: got kind=%0d edge=%0d want kind=%0d edge=%0d", o.kind, o.at, e.kind, e.at);
            end
        end
    endtask

    task automatic test_async_reset();
        // Four 1-samples leave the FSM in RISE_WAIT with cnt=2.
        hold(1'b1, 4);
        rst_n = 1'b0;
        #2;
        total++;
        if ({btn_level, btn_rise, btn_fall, btn_long} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset_qual: got %b want 0000", {btn_level, btn_rise, btn_fall, btn_long});
        end
        rst_n = 1'b1;
        exp_q.push_back(mk(0, accept_edge()));
        hold(1'b1, 12);
        rst_n = 1'b0;
        #2;
        total++;
        if ({btn_level, btn_rise, btn_fall, btn_long} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset_high: got %b want 0000", {btn_level, btn_rise, btn_fall, btn_long});
        end
        rst_n = 1'b1;
        exp_q.push_back(mk(0, accept_edge()));
        hold(1'b1, 12);
        exp_q.push_back(mk(1, accept_edge()));
        hold(1'b0, 12);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            ev_t e;
            ev_t o;
            e = mk(-1, -1);
            o = mk(-1, -1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            total++;
            if (o.kind !== e.kind || o.at !== e.at) begin
                bad++;
                $display("FAIL async_reset: got kind=%0d edge=%0d want kind=%0d edge=%0d", o.kind, o.at, e.kind, e.at);
            end
        end
    endtask

    task automatic test_long_press();
        int r;
        watch_long = 1'b1;
        r = accept_edge();
        exp_q.push_back(mk(0, r));
        if (LONG_EN) exp_q.push_back(mk(2, r + LG));
        hold(1'b1, 20);
        exp_q.push_back(mk(1, accept_edge()));
        hold(1'b0, 12);
        exp_q.push_back(mk(0, accept_edge()));
        hold(1'b1, 8);
        exp_q.push_back(mk(1, accept_edge()));
        hold(1'b0, 14);
        watch_long = 1'b0;
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            ev_t e;
            ev_t o;
            e = mk(-1, -1);
            o = mk(-1, -1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            total++;
            if (o.kind !== e.kind || o.at !== e.at) begin
                bad++;
                $display("FAIL long_press: got kind=%0d edge=%0d want kind=%0d edge=%0d", o.kind, o.at, e.kind, e.at);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press_release();
        test_bounce();
        test_glitch_high();
        test_async_reset();
        test_long_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
